// File: rtl/encoder_speed.sv
// encoder_speed: x4 quadrature decoder for the two balance-robot wheels.
// Each channel accumulates signed steps over a fixed window of clk cycles and
// reports magnitude + sign (saturated to 2^CNT_W-1) and an illegal-transition
// flag at the end of every window.
//
// Output handshake: sample_valid is a one-cycle strobe with no ready input.
// It is high in the cycle right after the window-end edge; the count, sign
// and err outputs are already updated in that cycle and hold their values
// until the next strobe, so a consumer may capture them on the strobe or at
// any time before the following one.
module encoder_speed #(
    parameter int WINDOW_CYCLES = 60000,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc1_a,
    input  logic             enc1_b,
    input  logic             enc2_a,
    input  logic             enc2_b,
    output logic [CNT_W-1:0] motor1_count,
    output logic             motor1_sign,
    output logic [CNT_W-1:0] motor2_count,
    output logic             motor2_sign,
    output logic             err1,
    output logic             err2,
    output logic             sample_valid
);

    localparam int TW = $clog2(WINDOW_CYCLES);
    localparam int AW = CNT_W + 2;
    localparam logic signed [AW-1:0] ACC_MAX    = AW'((2 ** CNT_W) - 1);
    localparam logic signed [AW-1:0] ACC_MIN    = -ACC_MAX;
    localparam logic [TW-1:0]        TIMER_LAST = TW'(WINDOW_CYCLES - 1);

    // Index 0 is motor 1, index 1 is motor 2; each pair is {A,B}.
    logic [1:0]           enc_raw  [2];
    logic [1:0]           sync1    [2];
    logic [1:0]           sync2    [2];
    logic [1:0]           prev     [2];
    logic signed [AW-1:0] acc      [2];
    logic                 win_err  [2];
    logic                 step_inc [2];
    logic                 step_dec [2];
    logic                 step_bad [2];
    logic [CNT_W-1:0]     count_q  [2];
    logic                 sign_q   [2];
    logic                 err_q    [2];

    logic                 primed;
    logic [TW-1:0]        timer;
    logic                 window_end;

    assign enc_raw[0] = {enc1_a, enc1_b};
    assign enc_raw[1] = {enc2_a, enc2_b};

    assign window_end = (timer == TIMER_LAST);

    // Decode one synchronized sample against the previous one.
    // Forward order is 00->01->11->10->00: for a single-bit change the move
    // is forward exactly when old A differs from new B.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            step_bad[c] = primed & (prev[c][1] ^ sync2[c][1]) & (prev[c][0] ^ sync2[c][0]);
            step_inc[c] = primed & ((prev[c][1] ^ sync2[c][1]) ^ (prev[c][0] ^ sync2[c][0]))
                                 & (prev[c][1] ^ sync2[c][0]);
            step_dec[c] = primed & ((prev[c][1] ^ sync2[c][1]) ^ (prev[c][0] ^ sync2[c][0]))
                                 & ~(prev[c][1] ^ sync2[c][0]);
        end
    end

    // Synchronizers, window timer, saturating accumulators and window results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            primed       <= 1'b0;
            timer        <= '0;
            sample_valid <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                sync1[c]   <= 2'b00;
                sync2[c]   <= 2'b00;
                prev[c]    <= 2'b00;
                acc[c]     <= '0;
                win_err[c] <= 1'b0;
                count_q[c] <= '0;
                sign_q[c]  <= 1'b0;
                err_q[c]   <= 1'b0;
            end
        end else begin
            primed       <= 1'b1;
            timer        <= window_end ? '0 : timer + TW'(1);
            sample_valid <= window_end;
            for (int c = 0; c < 2; c++) begin
                sync1[c] <= enc_raw[c];
                sync2[c] <= sync1[c];
                prev[c]  <= sync2[c];
                if (window_end) begin
                    // Report the closed window; this cycle's step opens the next one.
                    count_q[c] <= CNT_W'(acc[c][AW-1] ? -acc[c] : acc[c]);
                    sign_q[c]  <= acc[c][AW-1];
                    err_q[c]   <= win_err[c] | step_bad[c];
                    win_err[c] <= 1'b0;
                    if (step_inc[c])
                        acc[c] <= AW'(1);
                    else if (step_dec[c])
                        acc[c] <= '1;
                    else
                        acc[c] <= '0;
                end else begin
                    win_err[c] <= win_err[c] | step_bad[c];
                    if (step_inc[c] && acc[c] != ACC_MAX)
                        acc[c] <= acc[c] + AW'(1);
                    else if (step_dec[c] && acc[c] != ACC_MIN)
                        acc[c] <= acc[c] - AW'(1);
                end
            end
        end
    end

    assign motor1_count = count_q[0];
    assign motor1_sign  = sign_q[0];
    assign err1         = err_q[0];
    assign motor2_count = count_q[1];
    assign motor2_sign  = sign_q[1];
    assign err2         = err_q[1];

endmodule

// File: tb/tb_encoder_speed.sv
// tb_encoder_speed: randomized and directed stimulus for encoder_speed, with a
// window-level reference model (per-edge step lists folded at window end) and
// a per-cycle compare process plus literal expectations for the directed cases.
module tb_encoder_speed;

    localparam int W     = 400;
    localparam int CNT_W = 8;
    localparam int SAT   = (2 ** CNT_W) - 1;
    localparam int EW    = 2 * (CNT_W + 2);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enc1_a = 1'b0, enc1_b = 1'b0, enc2_a = 1'b0, enc2_b = 1'b0;
    logic [CNT_W-1:0] motor1_count, motor2_count;
    logic             motor1_sign, motor2_sign, err1, err2, sample_valid;

    int total = 0;
    int bad   = 0;

    encoder_speed #(.WINDOW_CYCLES(W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .enc1_a       (enc1_a),
        .enc1_b       (enc1_b),
        .enc2_a       (enc2_a),
        .enc2_b       (enc2_b),
        .motor1_count (motor1_count),
        .motor1_sign  (motor1_sign),
        .motor2_count (motor2_count),
        .motor2_sign  (motor2_sign),
        .err1         (err1),
        .err2         (err2),
        .sample_valid (sample_valid)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- compare helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pin history per channel: hist[c][j] is the pin pair seen j edges ago.
    logic [1:0]    hist [2][4];
    int            edge_n = 0;
    int            win_q1[$];
    int            win_q2[$];
    bit            werr [2] = '{1'b0, 1'b0};
    int            d [2];
    bit            ill [2];
    int            s1, s2, diff;
    logic [1:0]    cur [2];
    logic [CNT_W-1:0] m_cnt1 = '0, m_cnt2 = '0;
    logic          m_sign1 = 1'b0, m_sign2 = 1'b0, m_err1 = 1'b0, m_err2 = 1'b0;
    logic          m_valid = 1'b0;
    logic [EW-1:0] exp_q[$];

    function automatic int pos_of(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Sum of a window's steps, clamping at +-SAT after every step.
    function automatic int sat_sum(input int q[$]);
        int s = 0;
        foreach (q[i]) begin
            s += q[i];
            if (s > SAT) s = SAT;
            if (s < -SAT) s = -SAT;
        end
        return s;
    endfunction

    // Model: each edge k decodes the pin change seen at edges k-3 -> k-2;
    // every W-th edge since release closes a window.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_n = 0;
            for (int c = 0; c < 2; c++)
                for (int j = 0; j < 4; j++) hist[c][j] = 2'b00;
            win_q1.delete();
            win_q2.delete();
            werr = '{1'b0, 1'b0};
            m_cnt1 = '0; m_cnt2 = '0; m_sign1 = 1'b0; m_sign2 = 1'b0;
            m_err1 = 1'b0; m_err2 = 1'b0; m_valid = 1'b0;
            exp_q.delete();
        end else begin
            edge_n++;
            cur[0] = {enc1_a, enc1_b};
            cur[1] = {enc2_a, enc2_b};
            for (int c = 0; c < 2; c++) begin
                hist[c][3] = hist[c][2];
                hist[c][2] = hist[c][1];
                hist[c][1] = hist[c][0];
                hist[c][0] = cur[c];
                d[c] = 0;
                ill[c] = 1'b0;
                if (edge_n >= 2) begin
                    diff = (pos_of(hist[c][2]) - pos_of(hist[c][3]) + 4) % 4;
                    if (diff == 1) d[c] = 1;
                    else if (diff == 3) d[c] = -1;
                    else if (diff == 2) ill[c] = 1'b1;
                end
            end
            if (edge_n % W == 0) begin
                s1 = sat_sum(win_q1);
                s2 = sat_sum(win_q2);
                m_cnt1  = CNT_W'(s1 < 0 ? -s1 : s1);
                m_sign1 = (s1 < 0);
                m_err1  = werr[0] | ill[0];
                m_cnt2  = CNT_W'(s2 < 0 ? -s2 : s2);
                m_sign2 = (s2 < 0);
                m_err2  = werr[1] | ill[1];
                exp_q.push_back({m_err2, m_sign2, m_cnt2, m_err1, m_sign1, m_cnt1});
                m_valid = 1'b1;
                win_q1.delete();
                win_q2.delete();
                win_q1.push_back(d[0]);
                win_q2.push_back(d[1]);
                werr = '{1'b0, 1'b0};
            end else begin
                m_valid = 1'b0;
                win_q1.push_back(d[0]);
                win_q2.push_back(d[1]);
                werr[0] = werr[0] | ill[0];
                werr[1] = werr[1] | ill[1];
            end
        end
    end

    // ---------------- scoreboard: every falling edge ----------------
    logic [EW-1:0] exp_e;
    always @(negedge clk) begin
        chk("sample_valid", 32'(sample_valid), 32'(m_valid));
        chk("held_outputs",
            32'({err2, motor2_sign, motor2_count, err1, motor1_sign, motor1_count}),
            32'({m_err2, m_sign2, m_cnt2, m_err1, m_sign1, m_cnt1}));
        if (sample_valid === 1'b1) begin
            chk("exp_q_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_e = exp_q.pop_front();
                chk("window_result",
                    32'({err2, motor2_sign, motor2_count, err1, motor1_sign, motor1_count}),
                    32'(exp_e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [1:0] gray_tbl [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int pos1 = 0;
    int pos2 = 0;

    // dir: +1 forward, -1 reverse, 2 = both pins flip (illegal).
    task automatic do_step(input int ch, input int dir);
        if (ch == 1) begin
            pos1 = (pos1 + dir + 4) % 4;
            {enc1_a, enc1_b} = gray_tbl[pos1];
        end else begin
            pos2 = (pos2 + dir + 4) % 4;
            {enc2_a, enc2_b} = gray_tbl[pos2];
        end
    endtask

    task automatic steps(input int ch, input int dir, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            do_step(ch, dir);
            repeat (gap) @(negedge clk);
        end
    endtask

    // Returns the number of falling edges until sample_valid is seen.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sample_valid !== 1'b1 && n < 2 * W + 10);
        chk("valid_seen", 32'(sample_valid), 32'd1);
    endtask

    task automatic wait_edge_mod(input int target);
        int k = 0;
        while ((edge_n % W) != target && k < 2 * W) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic rand_drive(input int ch, input int cycles);
        int spent = 0;
        int r, g, dir;
        while (spent < cycles) begin
            r = $urandom_range(0, 19);
            if (r == 0) dir = 2;
            else if (r <= ((ch == 1) ? 12 : 6)) dir = 1;
            else dir = -1;
            do_step(ch, dir);
            g = $urandom_range(1, 4);
            repeat (g) @(negedge clk);
            spent += g;
        end
    endtask

    // ---------------- main sequence ----------------
    int n;
    initial begin
        repeat (5) @(negedge clk);
        chk("rst_cnt1", 32'(motor1_count), 32'd0);
        chk("rst_cnt2", 32'(motor2_count), 32'd0);
        chk("rst_sign", 32'({motor1_sign, motor2_sign}), 32'd0);
        chk("rst_err", 32'({err1, err2}), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);

        // Test 1: idle encoders. The strobe is first seen at the W-th falling
        // edge after release, i.e. in the cycle following rising edge W.
        reset = 1'b1;
        wait_valid(n);
        chk("t1_first_valid_latency", 32'(n), 32'(W));
        chk("t1_outputs", 32'({err2, motor2_sign, motor2_count, err1, motor1_sign, motor1_count}), 32'd0);

        // Test 2: 10 forward on enc1, 37 reverse on enc2.
        steps(1, 1, 10, 8);
        steps(2, -1, 37, 2);
        wait_valid(n);
        chk("t2_cnt1", 32'(motor1_count), 32'd10);
        chk("t2_sign1", 32'(motor1_sign), 32'd0);
        chk("t2_cnt2", 32'(motor2_count), 32'd37);
        chk("t2_sign2", 32'(motor2_sign), 32'd1);

        // Test 3: saturation both directions, then a cancelling window.
        fork
            steps(1, 1, 300, 1);
            steps(2, -1, 300, 1);
        join
        wait_valid(n);
        chk("t3_sat_cnt1", 32'(motor1_count), 32'd255);
        chk("t3_sat_sign1", 32'(motor1_sign), 32'd0);
        chk("t3_sat_cnt2", 32'(motor2_count), 32'd255);
        chk("t3_sat_sign2", 32'(motor2_sign), 32'd1);
        steps(1, 1, 5, 2);
        steps(1, -1, 5, 2);
        wait_valid(n);
        chk("t3_zero_cnt1", 32'(motor1_count), 32'd0);
        chk("t3_zero_sign1", 32'(motor1_sign), 32'd0);

        // Test 4: one illegal jump plus 3 forward steps, then a clean window.
        steps(1, 2, 1, 2);
        steps(1, 1, 3, 2);
        wait_valid(n);
        chk("t4_err1", 32'(err1), 32'd1);
        chk("t4_cnt1", 32'(motor1_count), 32'd3);
        wait_valid(n);
        chk("t4_clean_err1", 32'(err1), 32'd0);
        chk("t4_clean_cnt1", 32'(motor1_count), 32'd0);

        // Test 5: a forward step on enc1 and an illegal jump on enc2, both
        // decoded exactly on the window-end edge.
        wait_edge_mod(W - 3);
        do_step(1, 1);
        do_step(2, 2);
        wait_valid(n);
        chk("t5_edge_cnt1", 32'(motor1_count), 32'd0);
        chk("t5_edge_err2", 32'(err2), 32'd1);
        wait_valid(n);
        chk("t5_next_cnt1", 32'(motor1_count), 32'd1);
        chk("t5_next_sign1", 32'(motor1_sign), 32'd0);
        chk("t5_next_err2", 32'(err2), 32'd0);

        // Test 6: reset in the middle of a window holding 20 steps.
        steps(1, 1, 20, 2);
        wait_edge_mod(50);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_outputs", 32'({err2, motor2_sign, motor2_count, err1, motor1_sign, motor1_count}), 32'd0);
        chk("t6_rst_valid", 32'(sample_valid), 32'd0);
        pos1 = 0;
        pos2 = 0;
        {enc1_a, enc1_b, enc2_a, enc2_b} = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_no_valid_in_reset", 32'(sample_valid), 32'd0);
        end
        reset = 1'b1;
        steps(1, 1, 4, 2);
        wait_valid(n);
        chk("t6_restart_latency", 32'(n + 8), 32'(W));
        chk("t6_restart_cnt1", 32'(motor1_count), 32'd4);

        // Random phase: both channels concurrently, occasional illegal jumps.
        fork
            rand_drive(1, 5 * W);
            rand_drive(2, 5 * W);
        join
        wait_valid(n);
        wait_valid(n);
        @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encoder_speed.md
Name: encoder_speed

Overview:
- Measures the speed and direction of the two balance-robot wheels from their quadrature encoders.
- Produces the 8-bit magnitude plus sign format that the motor-drive block consumes, once per fixed sample window.
- Results go to the MCU for the balance control loop, which closes the loop around the H-bridge driver.
- Runs on the HSOSC-derived system clock (6 MHz).

Parameters:
WINDOW_CYCLES, 60000, sample window length in clk cycles (10 ms at 6 MHz); legal range is 4 or more.
CNT_W, 8, width of each reported magnitude; the saturation value is 2^CNT_W-1.

Ports:
clk  input  1  system clock, all logic on the rising edge
reset  input  1  asynchronous, active-low reset
enc1_a  input  1  motor 1 encoder channel A, asynchronous to clk
enc1_b  input  1  motor 1 encoder channel B, asynchronous to clk
enc2_a  input  1  motor 2 encoder channel A, asynchronous to clk
enc2_b  input  1  motor 2 encoder channel B, asynchronous to clk
motor1_count  output  CNT_W  motor 1 step magnitude over the last window
motor1_sign  output  1  motor 1 direction: 0 = forward/zero, 1 = reverse
motor2_count  output  CNT_W  motor 2 step magnitude over the last window
motor2_sign  output  1  motor 2 direction: 0 = forward/zero, 1 = reverse
err1  output  1  illegal transition seen on encoder 1 during the last window
err2  output  1  illegal transition seen on encoder 2 during the last window
sample_valid  output  1  one-cycle pulse when new results are presented

Behaviour:
- Reset (reset=0, asynchronous): every output is 0; timer, accumulators, error flags and synchronizers clear; the primed flag is 0.
- Input synchronization: each encoder pin passes through a 2-FF synchronizer, then a previous-state register holding {A,B}.
- Priming: on the first cycle after reset release, prev loads the synced value and no decode occurs; primed goes to 1.
- Decode (x4), per channel, state order {A,B} = 00→01→11→10→00:
  - One step in that order = +1.
  - One step in reverse order = -1.
  - No change = 0.
  - Both bits changing = illegal: no count, and the window error flag sets.
- Latency: a pin edge reaches the accumulator 3 clk edges later (2 sync + 1 decode).
- Accumulator: signed, CNT_W+2 bits per channel, saturating at ±(2^CNT_W-1). Further steps in the saturated direction are ignored; opposite steps still decrement/increment.
- Window timer:
  - Counts 0..WINDOW_CYCLES-1 and wraps.
  - On the cycle where timer = WINDOW_CYCLES-1 (window end), on the same edge:
    - motorN_count ← |accN|, already at most 2^CNT_W-1.
    - motorN_sign ← 1 if accN < 0, else 0. A zero count always gives sign 0.
    - errN ← window error flag, including an illegal transition decoded in that same cycle.
- Window end, simultaneous events:
  - Accumulators clear to the current cycle's decoded step (0 or ±1); a step decoded on the window-end cycle belongs to the new window.
  - Window error flags clear, unless the illegal transition occurred on the window-end cycle, in which case they are reported and not carried over.
- sample_valid: high exactly the one cycle after the window-end edge, so outputs are stable when it is seen.
- Hold: outputs keep their values between windows.
- First valid: the first sample_valid comes WINDOW_CYCLES+1 cycles after reset release.
- Reset mid-window: partial counts are discarded, no sample_valid is emitted, and timing restarts from 0.
- Channels are fully independent; simultaneous steps on both channels are both counted.

Test Plan:
1. Reset, encoders idle at 00, WINDOW_CYCLES=100 → all outputs 0; sample_valid first pulses 101 cycles after release with counts 0, signs 0, errs 0.
2. 10 forward steps on enc1 (8 cycles apart) and 37 reverse steps on enc2 within one window → motor1_count=10, sign=0; motor2_count=37, sign=1.
3. 300 forward steps on enc1 in one window (WINDOW_CYCLES=4000) → motor1_count=255, sign=0. Then 5 forward + 5 reverse in the next window → count=0, sign=0.
4. enc1 jumps 00→11 once plus 3 legal forward steps → err1=1, motor1_count=3. The following clean window → err1=0.
5. Forward step arriving so it decodes on the window-end cycle → excluded from the current result, reported as 1 in the next window.
6. reset asserted at cycle 50 of a window with 20 accumulated steps → outputs immediately 0, no sample_valid; the next window reports only steps after release.
